// File: rtl/de3_display_arbiter.sv
// de3_display_arbiter
// Round-robin owner of the shared 32-bit hex display path. A requester holds
// `req` high until it sees its one-cycle `ack`. At that point its data lane
// has been latched into `char`. The grant then holds the display for
// DWELL_CYCLES cycles before the block arbitrates again.
module de3_display_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          OWN_W        = 2,
  parameter int unsigned DWELL_CYCLES = 32'd1073741824
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]    ack,
  output logic [31:0]           char,
  output logic                  char_valid,
  output logic [OWN_W-1:0]      owner,
  output logic                  busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [31:0]      dwell;
  logic [OWN_W-1:0] last;

  logic             win_found;
  logic [OWN_W-1:0] win_idx;
  logic             grant;

  // Search from last+1 upwards (modulo NUM_REQ); the first active request wins.
  always_comb begin
    logic [OWN_W-1:0] cand;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OWN_W'((int'(last) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Requests are only looked at when idle or on the last cycle of a dwell.
  assign grant = win_found && ((state == IDLE) || (dwell == 32'd0));
  assign busy  = (state == HOLD);

  // Grant, dwell countdown and return to idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together from pre-edge values, with no ordering races.
    if (!rst_n) begin
      state      <= IDLE;
      dwell      <= 32'd0;
      last       <= OWN_W'(NUM_REQ - 1);
      ack        <= '0;
      char       <= 32'd0;
      char_valid <= 1'b0;
      owner      <= '0;
    end else begin
      ack <= '0;
      if (grant) begin
        char       <= data[32*win_idx +: 32];
        owner      <= win_idx;
        last       <= win_idx;
        ack        <= NUM_REQ'(1) << win_idx;
        char_valid <= 1'b1;
        dwell      <= 32'(DWELL_CYCLES - 1);
        state      <= HOLD;
      end else if (state == HOLD) begin
        if (dwell == 32'd0) begin
          state      <= IDLE;
          char_valid <= 1'b0;
        end else begin
          dwell <= dwell - 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_de3_display_arbiter.sv
// Testbench for de3_display_arbiter (NUM_REQ=4, DWELL_CYCLES=8).
// Every cycle the outputs are compared with a reference model. That model
// counts the display cycles left in the current grant. On top of this come a
// directed vector table, several hand-written sequences and a random phase.
module tb_de3_display_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [32*NR-1:0] data;
  logic [NR-1:0]   ack;
  logic [31:0]     char;
  logic            char_valid;
  logic [1:0]      owner;
  logic            busy;

  de3_display_arbiter #(
    .NUM_REQ(NR), .OWN_W(2), .DWELL_CYCLES(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack),
    .char(char), .char_valid(char_valid), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_left = display cycles still to show for the current grant (0 = idle).
  int          m_left;
  int          m_last;
  int          m_owner;
  logic [31:0] m_char;
  logic [NR-1:0] m_ack;

  task automatic model_step();
    int order[$];
    int w;
    if (!rst_n) begin
      m_left = 0; m_last = NR - 1; m_owner = 0; m_char = 32'd0; m_ack = '0;
    end else begin
      m_ack = '0;
      if (m_left <= 1 && req != '0) begin
        order = {};
        for (int k = 1; k <= NR; k++) order.push_back((m_last + k) % NR);
        w = -1;
        foreach (order[j]) if (w < 0 && req[order[j]]) w = order[j];
        m_char  = data[32*w +: 32];
        m_owner = w;
        m_last  = w;
        m_ack[w] = 1'b1;
        m_left  = DW;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  endtask

  // Update model from current inputs, clock, then compare after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("ack", 32'(ack), 32'(m_ack));
    check("char", char, m_char);
    check("char_valid", 32'(char_valid), 32'(m_left > 0));
    check("busy", 32'(busy), 32'(m_left > 0));
    check("owner", 32'(owner), 32'(m_owner));
  endtask

  // ---------------- grant recording for hand sequences ----------------
  int g_owner[$];
  int g_cycle[$];
  int g_valid;

  task automatic clear_rec();
    g_owner = {}; g_cycle = {}; g_valid = 0;
  endtask

  // Requesters drop their bit in the cycle they see ack.
  task automatic run_auto(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      if (ack != '0) begin
        g_owner.push_back(int'(owner));
        g_cycle.push_back(cyc);
      end
      if (char_valid) g_valid++;
      req = req & ~m_ack;
    end
  endtask

  function automatic int rec_owner(input int k);
    return (k < g_owner.size()) ? g_owner[k] : -1;
  endfunction

  function automatic int rec_gap(input int k);
    return (k < g_cycle.size() && k > 0) ? g_cycle[k] - g_cycle[k-1] : -1;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NR-1:0] exp_ack;
    logic          exp_valid;
    logic [1:0]    exp_owner;
    logic [31:0]   exp_char;
  } vec_t;

  vec_t vq[$];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    data[31:0]   = 32'hDEADBEEF;
    data[63:32]  = 32'hCAFEF00D;
    data[95:64]  = 32'h12345678;
    data[127:96] = 32'hA5A55A5A;

    // Reset with all requests high, then first grant to 0, then idle.
    for (int i = 0; i < 3; i++) vq.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 32'h0});
    vq.push_back('{1'b1, 4'b1111, 4'b0001, 1'b1, 2'd0, 32'hDEADBEEF});
    for (int i = 0; i < 7; i++) vq.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 2'd0, 32'hDEADBEEF});
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'hDEADBEEF});
    // Single requester 2.
    vq.push_back('{1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 32'h12345678});
    for (int i = 0; i < 7; i++) vq.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 2'd2, 32'h12345678});
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 32'h12345678});
    vq.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 32'h12345678});

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      req   = vq[i].req;
      tick();
      check("tbl_ack", 32'(ack), 32'(vq[i].exp_ack));
      check("tbl_valid", 32'(char_valid), 32'(vq[i].exp_valid));
      check("tbl_busy", 32'(busy), 32'(vq[i].exp_valid));
      check("tbl_owner", 32'(owner), 32'(vq[i].exp_owner));
      check("tbl_char", char, vq[i].exp_char);
    end

    // Round robin: all four request, order 0,1,2,3, 8 apart, 32 valid cycles.
    rst_n = 1'b0; req = '0; tick(); rst_n = 1'b1;
    clear_rec();
    req = 4'b1111;
    run_auto(34);
    check("rr_count", 32'(g_owner.size()), 32'd4);
    for (int k = 0; k < 4; k++) check("rr_order", 32'(rec_owner(k)), 32'(k));
    for (int k = 1; k < 4; k++) check("rr_gap", 32'(rec_gap(k)), 32'(DW));
    check("rr_valid_cycles", 32'(g_valid), 32'(4 * DW));

    // Wrap and fairness: last grant was 3, now 0 and 3 request.
    clear_rec();
    req = 4'b1001;
    run_auto(20);
    check("wrap_count", 32'(g_owner.size()), 32'd2);
    check("wrap_first", 32'(rec_owner(0)), 32'd0);
    check("wrap_second", 32'(rec_owner(1)), 32'd3);
    check("wrap_gap", 32'(rec_gap(1)), 32'(DW));

    // Owner re-request while 0 also waits: 0 wins at dwell end.
    clear_rec();
    req = 4'b0010;
    run_auto(3);
    req = req | 4'b0011;
    run_auto(26);
    check("rereq_count", 32'(g_owner.size()), 32'd3);
    check("rereq_0", 32'(rec_owner(0)), 32'd1);
    check("rereq_1", 32'(rec_owner(1)), 32'd0);
    check("rereq_2", 32'(rec_owner(2)), 32'd1);

    // Owner re-request alone: re-granted exactly 8 cycles later.
    clear_rec();
    req = 4'b0010;
    run_auto(3);
    req[1] = 1'b1;
    run_auto(20);
    check("regrant_count", 32'(g_owner.size()), 32'd2);
    check("regrant_0", 32'(rec_owner(0)), 32'd1);
    check("regrant_1", 32'(rec_owner(1)), 32'd1);
    check("regrant_gap", 32'(rec_gap(1)), 32'(DW));
    check("regrant_valid", 32'(g_valid), 32'(2 * DW));

    // Mid-grant reset at dwell==4, then arbitration restarts at requester 0.
    clear_rec();
    req = 4'b0100;
    run_auto(4);
    check("mid_owner_pre", 32'(owner), 32'd2);
    rst_n = 1'b0;
    tick();
    check("mid_char", char, 32'd0);
    check("mid_valid", 32'(char_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    clear_rec();
    req = 4'b1111;
    run_auto(1);
    check("mid_resume", 32'(rec_owner(0)), 32'd0);
    check("mid_resume_char", char, 32'hDEADBEEF);
    req = '0;
    run_auto(10);

    // Randomized traffic with occasional resets and abandoned requests.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(199) != 0);
      tick();
      for (int i = 0; i < NR; i++) begin
        if (m_ack[i]) begin
          req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(49) == 0) req[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          data[32*i +: 32] = $urandom;
          req[i] = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/de3_display_arbiter.md
# de3_display_arbiter

Round-robin scheduler that shares the board's single 32-bit hex display path between up to `NUM_REQ` debug requesters. It sits in front of the seven-segment display driver and drives that driver's `char` / `char_valid` inputs. Each granted requester owns the display for a fixed dwell time. The block then re-arbitrates. Requesters use a level-request / pulse-acknowledge handshake; the display value is captured at grant.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `OWN_W`, 2: owner index width, equals clog2(`NUM_REQ`).
- `DWELL_CYCLES`, 1073741824: cycles a grant is held (2^30 is 8 digits × 2^27 per digit). Simulation uses 8. Minimum 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  `NUM_REQ`  per-requester request level. Held high until the matching `ack` is seen.
- `data`  in  32*`NUM_REQ`  requester i's value on bits [32i+31:32i]. Must be stable while `req[i]` is high.
- `ack`  out  `NUM_REQ`  one-cycle grant/capture pulse per requester.
- `char`  out  32  value shown on the display.
- `char_valid`  out  1  high while a grant is being displayed.
- `owner`  out  `OWN_W`  index of the current or most recent grantee.
- `busy`  out  1  high in HOLD.

## Operation
- The FSM has two states: IDLE and HOLD. A down-counter `dwell` is 32 bits wide.
- A round-robin pointer `last` holds the most recent grantee. Search order is `last`+1, `last`+2, … modulo `NUM_REQ`. The first requester with `req` high in that order wins.
- **IDLE**
  - No request: stay in IDLE. `char_valid`=0 and `char` keeps its last value.
  - Any request: perform a grant to winner w.
- **Grant to w** (a single clock edge)
  - `char` <= `data[w]`, `owner` <= w, `last` <= w.
  - `ack[w]` <= 1 for exactly one cycle; all other `ack` bits are 0.
  - `char_valid` <= 1, `dwell` <= `DWELL_CYCLES`-1, state <= HOLD.
- **HOLD**
  - `dwell` decrements by 1 each cycle and `char` is frozen.
  - All `req` inputs are ignored, including a new request from the current owner.
- **HOLD with `dwell`==0**
  - Any `req` high: grant again on the same edge (back-to-back, `char_valid` stays 1). The owner can win again only if no other requester is asserting.
  - No request: go to IDLE and `char_valid` <= 0.
- A requester must drop `req` in the cycle `ack` is seen. Because `DWELL_CYCLES` ≥ 2, a stale `req` is never sampled twice.
- A request that drops before it is granted is simply not served. No error is flagged.
- `data` lanes of unrequested ports are don't-care.

## Timing
- **Reset values**: `char`=0, `char_valid`=0, `ack`=0, `owner`=0, `busy`=0, state=IDLE, `dwell`=0, `last`=`NUM_REQ`-1, so requester 0 has first priority.
- **Reset during HOLD**: the grant is aborted and all outputs take their reset values on the next edge. No `ack` is issued after reset.
- **Grant latency**: `req` sampled high in IDLE at edge N gives `ack`, `char`, `owner`, `char_valid`, `busy` updated after edge N, visible in cycle N+1.
- **Hold length**: `char_valid` stays high for exactly `DWELL_CYCLES` cycles per grant.
- **Back-to-back grant**: the next `ack` occurs `DWELL_CYCLES` cycles after the previous one, with no gap in `char_valid`.
- **Back to IDLE**: `char_valid` and `busy` fall in the cycle after `dwell` reaches 0, unless a re-grant happens.
- At most one `ack` bit is ever high, and never in two consecutive cycles when `DWELL_CYCLES` ≥ 2.
- **Pointer wrap**: when `last`=`NUM_REQ`-1, the search starts at 0.

## Test plan
(`NUM_REQ`=4, `DWELL_CYCLES`=8)
- **Reset**: hold `rst_n`=0 for 3 cycles with `req`=4'b1111 -> all outputs 0 and no `ack`. Release -> the first grant goes to requester 0 and `char` = `data[0]` (0xDEADBEEF).
- **Single requester**: `req[2]` pulsed until `ack`, `data[2]`=0x12345678 -> `ack`=4'b0100 for 1 cycle, `char`=0x12345678, `owner`=2, `char_valid` high for 8 cycles, then 0 with `char` retained.
- **Round robin**: `req`=4'b1111 held, each requester dropping its bit on its own `ack` -> grant order 0,1,2,3 with `ack` spaced 8 cycles apart and `char_valid` continuously high for 32 cycles.
- **Wrap and fairness**: start after a grant to 3, then `req`=4'b1001 -> the next grant is 0, then 3.
- **Owner re-request ignored**: `req[1]` raised again during requester 1's HOLD with `req[0]` also high -> at dwell end requester 0 wins. With `req[0]` low, requester 1 is re-granted after exactly 8 cycles.
- **Mid-grant reset**: assert `rst_n`=0 at `dwell`=4 -> the next cycle shows `char`=0, `char_valid`=0, `busy`=0, and arbitration resumes from requester 0.
